// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and memory-wait stalls,
// branch flushes, a data-memory timeout trap and stall/flush performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic [7:0] wait_inc;
    logic       lw_stall;
    logic       mem_stall;

    // Memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rs == rd_m)) begin
            return 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rs == rd_w)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            MemErr   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            MemErr   <= (state_next == ERROR);
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        wait_inc      = wait_cnt + 8'd1;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    wait_cnt_next = 8'd1;
                    state_next    = (MEM_TIMEOUT == 1) ? ERROR : MEMWAIT;
                end else begin
                    wait_cnt_next = 8'd0;
                end
            end
            MEMWAIT: begin
                if (!mem_stall) begin
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    wait_cnt_next = wait_inc;
                    if (wait_inc == TIMEOUT_LIM) begin
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

    // A memory wait freezes F..M and bubbles W; any resolved branch stays parked in Execute.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            StallF = 1'b0;
        end else if ((state == ERROR) || mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            StallCnt <= StallCnt + {{(CNT_W-1){1'b0}}, StallF};
            FlushCnt <= FlushCnt + {{(CNT_W-1){1'b0}}, FlushD};
        end
    end

endmodule
